// File: rtl/des_pkg.sv
// Shared DES constants: PC-1/PC-2 tables, rotation schedule, key-schedule states.
package des_pkg;

    localparam int NUM_ROUNDS = 16;
    localparam int SUBKEY_W   = 48;
    localparam int HALF_W     = 28;

    typedef enum logic [1:0] {IDLE, ROUND, READY} ks_state_t;

    // Table entries use DES bit numbering: bit 1 is the most significant bit.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [2*HALF_W-1:0] pc1(input logic [63:0] k);
        logic [2*HALF_W-1:0] r;
        for (int i = 0; i < 56; i++) begin
            r[55-i] = k[64-PC1[i]];
        end
        return r;
    endfunction

    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] v, input logic two);
        return two ? {v[HALF_W-3:0], v[HALF_W-1:HALF_W-2]} : {v[HALF_W-2:0], v[HALF_W-1]};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 compression of the 56-bit {C,D} pair into a 48-bit subkey.
module des_pc2
    import des_pkg::*;
(
    input  logic [2*HALF_W-1:0] cd,
    output logic [SUBKEY_W-1:0] subkey
);

    always_comb begin
        subkey = '0;
        for (int i = 0; i < SUBKEY_W; i++) begin
            subkey[SUBKEY_W-1-i] = cd[56-PC2[i]];
        end
    end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one subkey per cycle, all 16 held for the round pipeline.
module des_key_schedule
    import des_pkg::*;
(
    input  logic                           clock,
    input  logic                           reset,
    input  logic [63:0]                    key,
    input  logic                           key_load,
    output logic                           key_ready,
    output logic                           busy,
    output logic [NUM_ROUNDS*SUBKEY_W-1:0] subkeys,
    input  logic [3:0]                     round_sel,
    output logic [SUBKEY_W-1:0]            subkey_rd
);

    ks_state_t           state_q, state_d;
    logic [HALF_W-1:0]   c_q, c_d, d_q, d_d, c_rot, d_rot;
    logic [3:0]          rnd_q, rnd_d;
    logic                ready_q, ready_d, busy_q, busy_d, sk_we;
    logic [SUBKEY_W-1:0] pc2_out;
    logic [SUBKEY_W-1:0] sk_q [NUM_ROUNDS];
    logic                two;

    assign two   = (SHIFTS[rnd_q] == 2);
    assign c_rot = rotl(c_q, two);
    assign d_rot = rotl(d_q, two);

    des_pc2 u_pc2 (
        .cd     ({c_rot, d_rot}),
        .subkey (pc2_out)
    );

    // A load always wins, so a key_load mid-generation restarts cleanly from PC-1.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        rnd_d   = rnd_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        sk_we   = 1'b0;
        if (key_load) begin
            {c_d, d_d} = pc1(key);
            rnd_d      = '0;
            ready_d    = 1'b0;
            busy_d     = 1'b1;
            state_d    = ROUND;
        end else begin
            case (state_q)
                ROUND: begin
                    c_d   = c_rot;
                    d_d   = d_rot;
                    rnd_d = rnd_q + 4'd1;
                    sk_we = 1'b1;
                    if (rnd_q == 4'd15) begin
                        state_d = READY;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
                IDLE, READY: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            rnd_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            for (int k = 0; k < NUM_ROUNDS; k++) begin
                sk_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            rnd_q   <= rnd_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            if (sk_we) begin
                sk_q[rnd_q] <= pc2_out;
            end
        end
    end

    assign key_ready = ready_q;
    assign busy      = busy_q;
    assign subkey_rd = sk_q[round_sel];

    for (genvar k = 0; k < NUM_ROUNDS; k++) begin : g_flat
        assign subkeys[SUBKEY_W*(k+1)-1 -: SUBKEY_W] = sk_q[k];
    end

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: closed-form DES key-schedule model plus a per-cycle transaction model.
module tb_des_key_schedule;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         key_load = 1'b0;
    logic [63:0]  key = '0;
    logic [3:0]   round_sel = '0;
    logic         key_ready, busy;
    logic [767:0] subkeys;
    logic [47:0]  subkey_rd;

    int total = 0;
    int bad   = 0;
    bit chk   = 1'b0;

    des_key_schedule dut (
        .clock     (clock),
        .reset     (reset),
        .key       (key),
        .key_load  (key_load),
        .key_ready (key_ready),
        .busy      (busy),
        .subkeys   (subkeys),
        .round_sel (round_sel),
        .subkey_rd (subkey_rd)
    );

    always #5 clock = ~clock;

    localparam int T_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int T_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int T_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [55:0] model_pc1(input logic [63:0] k);
        logic [55:0] r;
        for (int i = 0; i < 56; i++) r[55-i] = k[64-T_PC1[i]];
        return r;
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] v, input int n);
        logic [55:0] t;
        t = {v, v};
        t = t >> (28 - n);
        return t[27:0];
    endfunction

    // Subkey j uses the PC-1 halves rotated by the cumulative shift count up to round j.
    function automatic logic [767:0] sched(input logic [63:0] k);
        logic [55:0]  cd, rcd;
        logic [47:0]  s;
        logic [767:0] r;
        int           cum;
        cd  = model_pc1(k);
        cum = 0;
        r   = '0;
        for (int j = 0; j < 16; j++) begin
            cum += T_SH[j];
            rcd = {rot28(cd[55:28], cum % 28), rot28(cd[27:0], cum % 28)};
            for (int i = 0; i < 48; i++) s[47-i] = rcd[56-T_PC2[i]];
            r[48*j +: 48] = s;
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [767:0] act, input logic [767:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    logic         m_ready = 1'b0, m_busy = 1'b0;
    int           m_cnt = 0;
    logic [767:0] m_target = '0, m_sk = '0;

    always @(posedge clock) begin
        if (!reset) begin
            m_ready = 1'b0;
            m_busy  = 1'b0;
            m_cnt   = 0;
            m_sk    = '0;
        end else if (key_load) begin
            m_target = sched(key);
            m_cnt    = 0;
            m_busy   = 1'b1;
            m_ready  = 1'b0;
        end else if (m_busy) begin
            m_sk[48*m_cnt +: 48] = m_target[48*m_cnt +: 48];
            m_cnt++;
            if (m_cnt == 16) begin
                m_busy  = 1'b0;
                m_ready = 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        if (chk) begin
            check("key_ready", {767'b0, key_ready}, {767'b0, m_ready});
            check("busy", {767'b0, busy}, {767'b0, m_busy});
            check("subkeys", subkeys, m_sk);
            check("subkey_rd", {720'b0, subkey_rd}, {720'b0, m_sk[48*round_sel +: 48]});
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic pulse(input logic [63:0] k);
        key      = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    task automatic wait_ready(input string nm, input int want);
        int n;
        n = 0;
        while (!key_ready && n < 40) begin
            tick();
            n++;
        end
        check(nm, 768'(n), 768'(want));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [767:0] ref_k;
        ref_k = sched(64'h133457799BBCDFF1);
        check("model_pc1", {712'b0, model_pc1(64'h133457799BBCDFF1)}, {712'b0, 28'hF0CCAAF, 28'h556678F});
        check("model_K1", {720'b0, ref_k[47:0]}, {720'b0, 48'h1B02EFFC7072});
        check("model_K16", {720'b0, ref_k[767 -: 48]}, {720'b0, 48'hCB3D8B0E17F5});

        tick();
        chk = 1'b1;
        tick();
        check("rst_ready", {767'b0, key_ready}, 768'd0);
        check("rst_busy", {767'b0, busy}, 768'd0);
        check("rst_subkeys", subkeys, 768'd0);
        for (int r = 0; r < 16; r++) begin
            round_sel = 4'(r);
            #1;
            check("rst_rd", {720'b0, subkey_rd}, 768'd0);
        end
        reset = 1'b1;
        tick();

        pulse(64'h133457799BBCDFF1);
        check("load_busy", {767'b0, busy}, 768'd1);
        wait_ready("known_latency", 16);
        check("known_busy", {767'b0, busy}, 768'd0);
        check("known_K1", {720'b0, subkeys[47:0]}, {720'b0, 48'h1B02EFFC7072});
        check("known_K16", {720'b0, subkeys[767 -: 48]}, {720'b0, 48'hCB3D8B0E17F5});
        for (int r = 0; r < 16; r++) begin
            round_sel = 4'(r);
            #1;
            check("readback_slice", {720'b0, subkey_rd}, {720'b0, subkeys[48*r +: 48]});
            check("readback_ref", {720'b0, subkey_rd}, {720'b0, ref_k[48*r +: 48]});
            tick();
        end

        pulse(64'h133457799BBCDFF1);
        repeat (4) tick();
        pulse(64'h0);
        wait_ready("restart_latency", 16);
        check("restart_zero", subkeys, 768'd0);

        pulse(64'h133457799BBCDFF1);
        repeat (6) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst_ready", {767'b0, key_ready}, 768'd0);
        check("midrst_busy", {767'b0, busy}, 768'd0);
        check("midrst_subkeys", subkeys, 768'd0);
        repeat (3) tick();
        check("midrst_idle", {766'b0, key_ready, busy}, 768'd0);

        pulse(64'h133457799BBCDFF1);
        wait_ready("pre_reload", 16);
        pulse(64'hFFFFFFFFFFFFFFFF);
        check("reload_drop", {767'b0, key_ready}, 768'd0);
        wait_ready("reload_latency", 16);
        check("reload_ones", subkeys, {768{1'b1}});

        for (int c = 0; c < 1500; c++) begin
            key       = {$urandom, $urandom};
            round_sel = 4'($urandom_range(0, 15));
            key_load  = ($urandom_range(0, 24) == 0);
            reset     = ($urandom_range(0, 199) != 0);
            tick();
        end
        key_load = 1'b0;
        reset    = 1'b1;
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
